// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   Serialises one parallel word into a UART frame:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
//   one stop bit (1). Every bit lasts N CLK cycles, N = latched Prescale
//   (Prescale = 0 behaves as N = 1).
//
//   Optional feature: parity support is compiled in only when the macro
//   UART_TX_PARITY_EN is defined. Without it PAR_EN / PAR_TYP are accepted
//   but ignored and the frame always goes DATA -> STOP.
//
// Ports
//   CLK        in   oversampling clock (single clock domain)
//   RST        in   asynchronous reset, active low
//   Prescale   in   [4:0] CLK cycles per serial bit
//   P_DATA     in   [DATA_WIDTH-1:0] parallel payload
//   Data_Valid in   request to send P_DATA (sampled only while idle)
//   PAR_EN     in   parity bit enable
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   TX_OUT     out  serial line, idle high, registered
//   Busy       out  frame in progress, registered
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [4:0]            Prescale,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [4:0]            r_n_m1;        // latched bit length minus one
   logic [4:0]            r_edge_cnt;
   logic [4:0]            w_edge_next;
   logic [CW-1:0]         r_bit_cnt;
   logic [CW-1:0]         w_bit_next;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_tx_next;
   logic                  w_busy_next;
   logic                  w_load;
   logic                  w_last_edge;
   logic                  w_parity_go;
   logic                  w_parity_bit;

`ifdef UART_TX_PARITY_EN
   logic r_par_en;
   logic r_par_typ;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
      end else if (w_load) begin
         r_par_en  <= PAR_EN;
         r_par_typ <= PAR_TYP;
      end
   end

   assign w_parity_go  = r_par_en;
   // Even parity is the plain XOR; odd parity inverts it.
   assign w_parity_bit = (^r_data) ^ r_par_typ;
`else
   // Parity hardware absent: ports are kept but deliberately unused.
   logic w_unused_par;
   assign w_unused_par = PAR_EN ^ PAR_TYP;
   assign w_parity_go  = 1'b0;
   assign w_parity_bit = 1'b1;
`endif

   assign w_last_edge = (r_edge_cnt == r_n_m1);

   // Next-state, counters and next serial-line value.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_state_next = r_state;
      w_edge_next  = r_edge_cnt;
      w_bit_next   = r_bit_cnt;
      w_load       = 1'b0;

      case (r_state)
         IDLE: begin
            if (Data_Valid) begin
               w_load       = 1'b1;
               w_edge_next  = 5'd0;
               w_bit_next   = '0;
               w_state_next = START;
            end
         end
         START: begin
            if (w_last_edge) begin
               w_edge_next  = 5'd0;
               w_bit_next   = '0;
               w_state_next = DATA;
            end else begin
               w_edge_next = r_edge_cnt + 5'd1;
            end
         end
         DATA: begin
            if (w_last_edge) begin
               w_edge_next = 5'd0;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_next   = '0;
                  w_state_next = w_parity_go ? PARITY : STOP;
               end else begin
                  w_bit_next = r_bit_cnt + 1'b1;
               end
            end else begin
               w_edge_next = r_edge_cnt + 5'd1;
            end
         end
         PARITY: begin
            if (w_last_edge) begin
               w_edge_next  = 5'd0;
               w_state_next = STOP;
            end else begin
               w_edge_next = r_edge_cnt + 5'd1;
            end
         end
         STOP: begin
            if (w_last_edge) begin
               w_edge_next  = 5'd0;
               w_state_next = IDLE;
            end else begin
               w_edge_next = r_edge_cnt + 5'd1;
            end
         end
         default: begin
            w_edge_next  = 5'd0;
            w_bit_next   = '0;
            w_state_next = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are registered yet
      // change on the same edge as the state (1-cycle acceptance latency).
      w_busy_next = (w_state_next != IDLE);
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = r_data[w_bit_next];
         PARITY:  w_tx_next = w_parity_bit;
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_edge_cnt <= 5'd0;
         r_bit_cnt  <= '0;
         // NOTE: the payload and bit-length registers are reset too, so a
         // reset mid-frame leaves no stale request behind.
         r_data     <= '0;
         r_n_m1     <= 5'd0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         r_state    <= w_state_next;
         r_edge_cnt <= w_edge_next;
         r_bit_cnt  <= w_bit_next;
         r_tx       <= w_tx_next;
         r_busy     <= w_busy_next;
         if (w_load) begin
            r_data <= P_DATA;
            r_n_m1 <= (Prescale == 5'd0) ? 5'd0 : (Prescale - 5'd1);
         end
      end
   end

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port CLK  input  1  oversampling clock, the same clock used by the receive path; the block has this one clock only.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Prescale  input  5  CLK cycles per serial bit.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-006 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-007 SHALL have port PAR_EN  input  1  parity bit enable.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port TX_OUT  output  1  serial line; idle high; registered.
REQ-010 SHALL have port Busy  output  1  frame in progress; registered.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a request in IDLE when Data_Valid=1, latching P_DATA, Prescale, PAR_EN and PAR_TYP on that edge, then entering START.
REQ-013 SHALL ignore Data_Valid while Busy=1, with no relatch and no queuing.
REQ-014 SHALL drive TX_OUT=0 and Busy=1 from the cycle after acceptance, so latency is 1 cycle.
REQ-015 SHALL hold each bit for exactly N CLK cycles, where N = latched Prescale, and Prescale=0 is treated as N=1.
REQ-016 SHALL time bits with an internal edge counter running 0..N-1; at N-1 the counter wraps to 0 and the bit advances.
REQ-017 SHALL transmit the DATA bits LSB first, using a bit counter 0..DATA_WIDTH-1 and leaving DATA when the last bit completes.
REQ-018 SHALL go from DATA to PARITY when the latched PAR_EN=1, and otherwise go directly to STOP.
REQ-019 SHALL compute the parity bit as XOR of the latched data for even, and as inverted XOR for odd.
REQ-020 SHALL send a single stop bit, TX_OUT=1, lasting N cycles.
REQ-021 SHALL deassert Busy on the cycle after the last STOP cycle and return to IDLE.
REQ-022 SHALL allow back-to-back frames: Data_Valid=1 on the first IDLE cycle starts the next frame with no extra idle gap beyond that cycle.
REQ-023 SHALL ignore changes on Prescale, P_DATA, PAR_EN and PAR_TYP mid-frame.
REQ-024 SHALL give a total frame length of N*(DATA_WIDTH+2) cycles without parity and N*(DATA_WIDTH+3) cycles with parity.

Reset
REQ-025 SHALL, when RST=0 asserts at any time including mid-frame, immediately force TX_OUT=1, Busy=0, state IDLE, and clear all counters and latched registers.
REQ-026 SHALL accept a request on the first rising CLK edge after RST deasserts if Data_Valid=1.

Configuration
REQ-027 SHALL compile parity support in when macro UART_TX_PARITY_EN is defined, behaving per REQ-018/019.
REQ-028 SHALL, when UART_TX_PARITY_EN is undefined, keep PAR_EN and PAR_TYP ports but ignore them, make the PARITY state unreachable, and always go DATA->STOP.

Verification
REQ-029 SHALL cover: Prescale=8, P_DATA=0xA5, PAR_EN=0, pulse Data_Valid -> TX_OUT reads 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles wide; Busy high for exactly 80 cycles.
REQ-030 SHALL cover: Prescale=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; with PAR_TYP=1 -> parity bit 1; Busy high for 88 cycles each.
REQ-031 SHALL cover: Data_Valid held high with P_DATA=0x3C then 0xC3 -> two frames separated by exactly 1 idle cycle; the second frame carries 0xC3; P_DATA changes mid-frame have no effect.
REQ-032 SHALL cover: Prescale changed from 16 to 8 mid-frame -> current frame keeps 16-cycle bits; the next frame uses 8-cycle bits.
REQ-033 SHALL cover: RST pulsed low during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately; a new request after release gives a clean full frame.
REQ-034 SHALL cover: Prescale=0, P_DATA=0xFF -> 1-cycle bits, 10-cycle frame; with UART_TX_PARITY_EN undefined and PAR_EN=1 -> still 10 cycles, no parity bit.
